// File: rtl/ins_fetch_queue_pkg.sv
// Shared constants and types for the instruction fetch queue.
// Start address, state encodings and the queue entry layout.
package ins_fetch_queue_pkg;

   localparam logic [31:0] INS_START_ADDRESS = 32'h0000_0000;
   localparam logic [31:0] WORD_INC = 32'd4;

   typedef enum logic [1:0] {
      ST_RESET = 2'd0,
      ST_FETCH = 2'd1,
      ST_FLUSH = 2'd2
   } fq_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] ins;
   } fq_entry_t;

endpackage

// File: rtl/ins_fetch_queue_fetch_fifo.sv
// Parameterised synchronous FIFO holding fetched {PC, instruction} entries.
// Storage is cleared on reset so the head reads as zero out of reset.
module fetch_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= wdata;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/ins_fetch_queue.sv
// Instruction fetch queue: credit-limited fetch, in-order response queue,
// and redirect handling that drops in-flight responses while flushing.
module ins_fetch_queue
   import ins_fetch_queue_pkg::*;
#(
   parameter int          DEPTH         = 4,
   parameter logic [31:0] START_ADDRESS = INS_START_ADDRESS
) (
   input  logic        SYS_clk,
   input  logic        SYS_reset,
   output logic        IMEM_req_valid,
   output logic [31:0] IMEM_req_addr,
   input  logic        IMEM_req_ready,
   input  logic        IMEM_resp_valid,
   input  logic [31:0] IMEM_resp_data,
   output logic        FQ_valid,
   output logic [31:0] FQ_instruction,
   output logic [31:0] FQ_PC,
   input  logic        FQ_ready,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_PC
);

   localparam int CW = $clog2(DEPTH) + 1;

   fq_state_t     state;
   fq_state_t     state_next;
   logic [31:0]   fetch_pc;
   logic [31:0]   rsp_pc;
   logic [31:0]   redir_pc;
   logic [CW-1:0] occ;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] discard_next;
   logic [CW:0]   credits;
   logic          in_fetch;
   logic          in_flush;
   logic          req_fire;
   logic          push;
   logic          pop;
   logic          redirect_fetch;
   logic          fifo_full;
   logic          fifo_empty;
   fq_entry_t     wr_entry;
   fq_entry_t     head;

   assign redir_pc       = redirect_PC & ~32'h3;
   assign credits        = {1'b0, occ} + {1'b0, outstanding};
   assign req_fire       = IMEM_req_valid && IMEM_req_ready;
   assign redirect_fetch = in_fetch && redirect_valid;
   assign push           = in_fetch && IMEM_resp_valid && !redirect_valid;
   assign pop            = FQ_valid && FQ_ready && !redirect_valid;
   assign wr_entry       = '{pc: rsp_pc, ins: IMEM_resp_data};

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fq_entry_t))
   ) u_fifo (
      .clk   (SYS_clk),
      .rst   (SYS_reset),
      .flush (redirect_fetch),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occ)
   );

   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) begin
         state <= ST_RESET;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      unique case (state)
         ST_RESET: state_next = ST_FETCH;
         ST_FETCH: begin
            if (redirect_valid && discard_next != '0) begin
               state_next = ST_FLUSH;
            end
         end
         ST_FLUSH: begin
            if (!redirect_valid && discard_next == '0) begin
               state_next = ST_FETCH;
            end
         end
         default: state_next = ST_RESET;
      endcase
   end

   always_comb begin
      in_fetch = 1'b0;
      in_flush = 1'b0;
      unique case (state)
         ST_FETCH: in_fetch = 1'b1;
         ST_FLUSH: in_flush = 1'b1;
         default:  ;
      endcase
   end

   assign IMEM_req_valid = in_fetch && !redirect_valid && !SYS_reset
                         && !fifo_full
                         && (credits < (CW+1)'(DEPTH));
   assign IMEM_req_addr  = fetch_pc;
   assign FQ_valid       = !fifo_empty && !SYS_reset;
   assign FQ_instruction = head.ins;
   assign FQ_PC          = head.pc;

   // A response in the redirect cycle is one of the in-flight ones to drop.
   always_comb begin
      discard_next = discard;
      if (redirect_fetch) begin
         discard_next = outstanding - CW'(IMEM_resp_valid);
      end else if (in_flush && IMEM_resp_valid && discard != '0) begin
         discard_next = discard - 1'b1;
      end
   end

   always_ff @(posedge SYS_clk) begin
      if (SYS_reset) begin
         fetch_pc    <= START_ADDRESS;
         rsp_pc      <= START_ADDRESS;
         outstanding <= '0;
         discard     <= '0;
      end else begin
         discard <= discard_next;
         if (redirect_valid && (in_fetch || in_flush)) begin
            fetch_pc <= redir_pc;
            rsp_pc   <= redir_pc;
         end else begin
            if (req_fire) fetch_pc <= fetch_pc + WORD_INC;
            if (push)     rsp_pc   <= rsp_pc + WORD_INC;
         end
         if (redirect_fetch) begin
            outstanding <= '0;
         end else begin
            unique case ({req_fire, push})
               2'b10:   outstanding <= outstanding + 1'b1;
               2'b01:   outstanding <= outstanding - 1'b1;
               default: outstanding <= outstanding;
            endcase
         end
      end
   end

endmodule
